rv_hazard_fwd_unit: RTL and testbench
=====================================

Name: rv_hazard_fwd_unit

Overview:
- Parametrised pipeline hazard, forwarding and stall controller for the RV32I core.
- Sits between decode and execute. Tracks every in-flight instruction from execute through writeback in a NUM_STAGES-deep scoreboard.
- Selects forwarded operands for the issuing instruction and raises stall on load-use hazards.
- Replaces the fixed single-stage exec bypass with arbitrary depth, load latency, memory freeze, branch-flush gating and a stall performance counter.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- NUM_STAGES, 3, tracked slots (slot 0 = execute, slot NUM_STAGES-1 = writeback); legal range 2..7.
- LOAD_READY, 1, first slot index whose output carries valid load data; legal range 1..NUM_STAGES-1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1_addr / issue_rs2_addr  in  REG_AW  source addresses.
- issue_rs1_used / issue_rs2_used  in  1  source actually read.
- issue_rd_addr  in  REG_AW  destination.
- issue_rd_we  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- rf_rs1_data / rf_rs2_data  in  XLEN  register-file read data.
- stage_rd_data  in  NUM_STAGES*XLEN  result of slot k at bits [k*XLEN +: XLEN].
- mem_busy  in  1  data memory not ready; freezes the scoreboard.
- flush  in  1  taken branch; current issue is discarded.
- cnt_clr  in  1  synchronous clear of stall_count.
- issue_accept  out  1  instruction enters slot 0 this cycle.
- stall  out  1  hold decode/fetch (combinational).
- rs1_fwd_sel / rs2_fwd_sel  out  clog2(NUM_STAGES+1)  0 = register file, k+1 = slot k.
- rs1_data / rs2_data  out  XLEN  resolved operands.
- wb_valid  out  1  slot NUM_STAGES-1 valid.
- wb_rd_addr  out  REG_AW  its rd.
- wb_rd_we  out  1  its write enable.
- stall_count  out  CNT_W  saturating stall-cycle counter.

Behaviour:
- **Slot contents:** each slot holds valid, rd_addr, rd_we and is_load.
- **Reset:**
  - All slots invalid; stall_count = 0.
  - wb_valid = 0, wb_rd_addr = 0, wb_rd_we = 0.
  - Hence stall = 0, issue_accept = issue_valid, fwd_sel = 0.
  - Reset asserted mid-operation clears all state immediately; in-flight instructions are lost.
- **Match:** slot k matches source s when slot valid, rd_we = 1, rd_addr = s, s != 0, and the source's used flag = 1.
  - x0 never matches and never stalls.
- **Priority:** the lowest matching k (youngest) wins. Older matches are ignored even when ready.
- **Ready:** the winning slot is ready if !is_load, or k >= LOAD_READY.
  - Ready: fwd_sel = k+1 and data = stage_rd_data slot k.
  - Not ready: hazard.
  - No match: fwd_sel = 0 and data = rf data.
- **Stall:** stall = issue_valid & !flush & (hazard on rs1 | hazard on rs2).
  - mem_busy does not assert stall; it freezes the pipe instead.
- **Accept:** issue_accept = issue_valid & !stall & !flush & !mem_busy.
- **Shift (posedge, mem_busy = 0):**
  - slot[i+1] <= slot[i].
  - slot[0] <= accepted instruction, else a bubble (valid = 0).
  - The old slot NUM_STAGES-1 retires.
- **Freeze (mem_busy = 1):** all slots hold; fwd_sel and data keep tracking the unchanged slots.
- **wb_* outputs:** direct copies of the registered last slot, so 0 latency from slot state.
- **Flush:** blocks acceptance for that cycle only. Already-issued slots are never killed. Flush with mem_busy is legal; upstream holds flush until its own redirect completes.
- **stall_count:**
  - +1 on each cycle with stall = 1 & mem_busy = 0.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- **Same-cycle writeback:** a same-cycle writeback to the issuing source is forwarded from the last slot, because register-file write-then-read is not assumed to bypass.

Test Plan:
- ADD x5 issued, next cycle ADD x6,x5,x5 -> rs1_fwd_sel = rs2_fwd_sel = 1, data = slot0 value 0x0000_1234, no stall.
- LW x7 then ADD x8,x7,x0 (defaults):
  - Cycle 1: stall = 1, issue_accept = 0.
  - Cycle 2: rs1_fwd_sel = 2, accept; stall_count = 1.
- Writes to x3 in slot0 (0xAA) and slot2 (0xBB), consumer reads x3 -> sel = 1, data 0xAA. Load x3 in slot0 with non-load x3 in slot2 -> stall despite the older ready copy.
- Instruction writing x0 in slot0, consumer reads x0 -> sel = 0, no stall, data = rf data.
- mem_busy held 3 cycles during a load-use stall -> slots frozen, stall_count unchanged, wb_valid constant; release resumes normal shift.
- flush with issue_valid = 1 -> issue_accept = 0, slot0 bubble next cycle. Also: rst pulse mid-stream -> all slots invalid, stall = 0 asynchronously. Also: CNT_W = 2 saturates at 3.

Source files
------------

// File: rtl/rv_hazard_fwd_unit.sv
// rtl/rv_hazard_fwd_unit.sv - scoreboard-based hazard, forwarding and stall control for RV32I
// Tracks in-flight writers from execute to writeback and resolves the issuing instruction's operands.
module rv_hazard_fwd_unit #(
   parameter int XLEN       = 32,
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_READY = 1,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic [REG_AW-1:0]          issue_rs1_addr,
   input  logic [REG_AW-1:0]          issue_rs2_addr,
   input  logic                       issue_rs1_used,
   input  logic                       issue_rs2_used,
   input  logic [REG_AW-1:0]          issue_rd_addr,
   input  logic                       issue_rd_we,
   input  logic                       issue_is_load,
   input  logic [XLEN-1:0]            rf_rs1_data,
   input  logic [XLEN-1:0]            rf_rs2_data,
   input  logic [NUM_STAGES*XLEN-1:0] stage_rd_data,
   input  logic                       mem_busy,
   input  logic                       flush,
   input  logic                       cnt_clr,
   output logic                       issue_accept,
   output logic                       stall,
   output logic [SEL_W-1:0]           rs1_fwd_sel,
   output logic [SEL_W-1:0]           rs2_fwd_sel,
   output logic [XLEN-1:0]            rs1_data,
   output logic [XLEN-1:0]            rs2_data,
   output logic                       wb_valid,
   output logic [REG_AW-1:0]          wb_rd_addr,
   output logic                       wb_rd_we,
   output logic [CNT_W-1:0]           stall_count
);

   logic [NUM_STAGES-1:0] slot_valid;
   logic [NUM_STAGES-1:0] slot_we;
   logic [NUM_STAGES-1:0] slot_load;
   logic [REG_AW-1:0]     slot_rd [NUM_STAGES];

   logic rs1_hit, rs1_rdy, rs2_hit, rs2_rdy;
   logic rs1_hazard, rs2_hazard;

   // Walk from oldest to youngest so the youngest matching slot overrides older ones.
   always_comb begin
      rs1_hit     = 1'b0;
      rs1_rdy     = 1'b0;
      rs1_fwd_sel = '0;
      rs1_data    = rf_rs1_data;
      rs2_hit     = 1'b0;
      rs2_rdy     = 1'b0;
      rs2_fwd_sel = '0;
      rs2_data    = rf_rs2_data;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (slot_valid[k] && slot_we[k] && issue_rs1_used &&
             issue_rs1_addr != '0 && slot_rd[k] == issue_rs1_addr) begin
            rs1_hit     = 1'b1;
            rs1_rdy     = !slot_load[k] || (k >= LOAD_READY);
            rs1_fwd_sel = SEL_W'(k + 1);
            rs1_data    = stage_rd_data[k*XLEN +: XLEN];
         end
         if (slot_valid[k] && slot_we[k] && issue_rs2_used &&
             issue_rs2_addr != '0 && slot_rd[k] == issue_rs2_addr) begin
            rs2_hit     = 1'b1;
            rs2_rdy     = !slot_load[k] || (k >= LOAD_READY);
            rs2_fwd_sel = SEL_W'(k + 1);
            rs2_data    = stage_rd_data[k*XLEN +: XLEN];
         end
      end
   end

   assign rs1_hazard   = rs1_hit && !rs1_rdy;
   assign rs2_hazard   = rs2_hit && !rs2_rdy;
   assign stall        = issue_valid && !flush && (rs1_hazard || rs2_hazard);
   assign issue_accept = issue_valid && !stall && !flush && !mem_busy;

   // A busy data memory freezes every slot, so forwarding keeps tracking the same producers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid <= '0;
         slot_we    <= '0;
         slot_load  <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            slot_rd[i] <= '0;
         end
      end else if (!mem_busy) begin
         for (int i = NUM_STAGES - 1; i > 0; i--) begin
            slot_valid[i] <= slot_valid[i-1];
            slot_we[i]    <= slot_we[i-1];
            slot_load[i]  <= slot_load[i-1];
            slot_rd[i]    <= slot_rd[i-1];
         end
         slot_valid[0] <= issue_accept;
         slot_we[0]    <= issue_accept && issue_rd_we;
         slot_load[0]  <= issue_accept && issue_is_load;
         slot_rd[0]    <= issue_accept ? issue_rd_addr : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (cnt_clr) begin
         stall_count <= '0;
      end else if (stall && !mem_busy && stall_count != '1) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign wb_valid   = slot_valid[NUM_STAGES-1];
   assign wb_rd_addr = slot_rd[NUM_STAGES-1];
   assign wb_rd_we   = slot_we[NUM_STAGES-1];

endmodule

// File: tb/tb_rv_hazard_fwd_unit.sv
// tb/tb_rv_hazard_fwd_unit.sv - self-checking bench for rv_hazard_fwd_unit
module tb_rv_hazard_fwd_unit;
   localparam int NS = 3;
   localparam int LR = 1;
   localparam logic [31:0] RF1 = 32'h1111_1111;
   localparam logic [31:0] RF2 = 32'h2222_2222;
   localparam logic [31:0] C0 = 32'hC0C0_0000;
   localparam logic [31:0] C1 = 32'hC1C1_0001;
   localparam logic [31:0] C2 = 32'hC2C2_0002;

   logic clk = 1'b0;
   logic rst;
   logic issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we, issue_is_load;
   logic [4:0] issue_rs1_addr, issue_rs2_addr, issue_rd_addr;
   logic [31:0] rf_rs1_data, rf_rs2_data;
   logic [31:0] sd [NS];
   logic [NS*32-1:0] stage_rd_data;
   logic mem_busy, flush, cnt_clr;

   logic issue_accept, stall, wb_valid, wb_rd_we;
   logic [1:0] rs1_fwd_sel, rs2_fwd_sel;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0] wb_rd_addr;
   logic [15:0] stall_count;

   logic s_accept, s_stall, s_wb_valid, s_wb_rd_we;
   logic [1:0] s_sel1, s_sel2;
   logic [31:0] s_d1, s_d2;
   logic [4:0] s_wb_rd;
   logic [1:0] s_count;

   int n_cmp = 0;
   int n_bad = 0;

   assign stage_rd_data = {sd[2], sd[1], sd[0]};

   always #5 clk = ~clk;

   rv_hazard_fwd_unit #(.NUM_STAGES(NS), .LOAD_READY(LR)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid),
      .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
      .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
      .issue_rd_addr(issue_rd_addr), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .stage_rd_data(stage_rd_data),
      .mem_busy(mem_busy), .flush(flush), .cnt_clr(cnt_clr),
      .issue_accept(issue_accept), .stall(stall),
      .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
      .stall_count(stall_count)
   );

   rv_hazard_fwd_unit #(.NUM_STAGES(NS), .LOAD_READY(LR), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .issue_valid(issue_valid),
      .issue_rs1_addr(issue_rs1_addr), .issue_rs2_addr(issue_rs2_addr),
      .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
      .issue_rd_addr(issue_rd_addr), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .stage_rd_data(stage_rd_data),
      .mem_busy(mem_busy), .flush(flush), .cnt_clr(cnt_clr),
      .issue_accept(s_accept), .stall(s_stall),
      .rs1_fwd_sel(s_sel1), .rs2_fwd_sel(s_sel2),
      .rs1_data(s_d1), .rs2_data(s_d2),
      .wb_valid(s_wb_valid), .wb_rd_addr(s_wb_rd), .wb_rd_we(s_wb_rd_we),
      .stall_count(s_count)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic we, ld, fl, mb;
      logic [31:0] s0, s1, s2;
      logic st, acc; logic [1:0] sel1, sel2; logic [31:0] d1, d2;
      logic wbv; logic [4:0] wbrd; logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
      input logic [4:0] rd, input logic we, input logic ld, input logic fl, input logic mb,
      input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
      input logic st, input logic acc, input logic [1:0] sel1, input logic [1:0] sel2,
      input logic [31:0] d1, input logic [31:0] d2,
      input logic wbv, input logic [4:0] wbrd, input logic [15:0] cnt);
      vec_t r;
      r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd; r.we = we; r.ld = ld;
      r.fl = fl; r.mb = mb; r.s0 = s0; r.s1 = s1; r.s2 = s2; r.st = st; r.acc = acc;
      r.sel1 = sel1; r.sel2 = sel2; r.d1 = d1; r.d2 = d2; r.wbv = wbv; r.wbrd = wbrd; r.cnt = cnt;
      return r;
   endfunction

   task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic fl, input logic mb);
      issue_valid = v; issue_rs1_addr = rs1; issue_rs2_addr = rs2;
      issue_rs1_used = u1; issue_rs2_used = u2; issue_rd_addr = rd;
      issue_rd_we = we; issue_is_load = ld; flush = fl; mem_busy = mb;
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic v; logic [4:0] rd; logic we; logic ld; } mslot_t;
   mslot_t pipe[$];
   int mcnt, mcnt_sat;

   task automatic model_reset();
      mslot_t e;
      e = '0;
      pipe.delete();
      for (int i = 0; i < NS; i++) pipe.push_back(e);
      mcnt = 0;
      mcnt_sat = 0;
   endtask

   // Youngest producer of src, or -1; ready says whether its value is usable now.
   task automatic lookup(input logic [4:0] src, input logic used, output int kh, output logic ready);
      kh = -1;
      ready = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (kh < 0 && used && src != 0 && pipe[k].v && pipe[k].we && pipe[k].rd == src) kh = k;
      end
      if (kh >= 0) ready = !pipe[kh].ld || kh >= LR;
   endtask

   vec_t tbl[18];

   initial begin
      int k1, k2;
      logic r1, r2, hz1, hz2, e_st, e_acc;
      mslot_t e;

      rst = 1'b1;
      cnt_clr = 1'b0;
      rf_rs1_data = RF1;
      rf_rs2_data = RF2;
      sd[0] = C0; sd[1] = C1; sd[2] = C2;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, C1, C2, 0, 0, 0, 0, RF1, RF2, 0, 0, 0);
      tbl[1]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 0, 0, 0);
      tbl[2]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 32'h1234, C1, C2, 0, 1, 1, 1, 32'h1234, 32'h1234, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 1, 0, 7, 1, 1, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 0, 0, 0);
      tbl[4]  = mk(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, C0, C1, C2, 1, 0, 0, 0, RF1, RF2, 1, 5, 0);
      tbl[5]  = mk(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, C0, 32'h7777, C2, 0, 1, 2, 0, 32'h7777, RF2, 1, 6, 1);
      tbl[6]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 1, 7, 1);
      tbl[7]  = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 0, 0, 1);
      tbl[8]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 1, 8, 1);
      tbl[9]  = mk(1, 3, 3, 1, 1, 0, 1, 0, 0, 0, 32'hAA, C1, 32'hBB, 0, 1, 1, 1, 32'hAA, 32'hAA, 1, 3, 1);
      tbl[10] = mk(1, 0, 0, 1, 1, 3, 1, 1, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 1, 9, 1);
      tbl[11] = mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 1, C0, C1, C2, 1, 0, 0, 0, RF1, RF2, 1, 3, 1);
      tbl[12] = mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 1, C0, C1, C2, 1, 0, 0, 0, RF1, RF2, 1, 3, 1);
      tbl[13] = mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 1, C0, C1, C2, 1, 0, 0, 0, RF1, RF2, 1, 3, 1);
      tbl[14] = mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 0, C0, C1, C2, 1, 0, 0, 0, RF1, RF2, 1, 3, 1);
      tbl[15] = mk(1, 3, 0, 1, 1, 11, 1, 0, 0, 0, C0, 32'h3333, C2, 0, 1, 2, 0, 32'h3333, RF2, 1, 0, 2);
      tbl[16] = mk(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, C0, C1, C2, 0, 0, 0, 0, RF1, RF2, 1, 3, 2);
      tbl[17] = mk(1, 10, 0, 1, 0, 12, 0, 0, 0, 0, C0, C1, C2, 0, 1, 0, 0, RF1, RF2, 0, 0, 2);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         set_in(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                tbl[i].we, tbl[i].ld, tbl[i].fl, tbl[i].mb);
         sd[0] = tbl[i].s0; sd[1] = tbl[i].s1; sd[2] = tbl[i].s2;
         #1;
         chk($sformatf("tbl%0d stall", i), 64'(stall), 64'(tbl[i].st));
         chk($sformatf("tbl%0d accept", i), 64'(issue_accept), 64'(tbl[i].acc));
         if (!tbl[i].st) begin
            chk($sformatf("tbl%0d rs1_sel", i), 64'(rs1_fwd_sel), 64'(tbl[i].sel1));
            chk($sformatf("tbl%0d rs2_sel", i), 64'(rs2_fwd_sel), 64'(tbl[i].sel2));
            chk($sformatf("tbl%0d rs1_data", i), 64'(rs1_data), 64'(tbl[i].d1));
            chk($sformatf("tbl%0d rs2_data", i), 64'(rs2_data), 64'(tbl[i].d2));
         end
         chk($sformatf("tbl%0d wb_valid", i), 64'(wb_valid), 64'(tbl[i].wbv));
         if (tbl[i].wbv) chk($sformatf("tbl%0d wb_rd", i), 64'(wb_rd_addr), 64'(tbl[i].wbrd));
         chk($sformatf("tbl%0d count", i), 64'(stall_count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d count_sat", i), 64'(s_count), 64'(tbl[i].cnt));
         @(posedge clk);
         @(negedge clk);
      end

      // Asynchronous reset while a load-use stall is being raised.
      sd[0] = C0; sd[1] = C1; sd[2] = C2;
      set_in(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
      #1 chk("rst_seq load accept", 64'(issue_accept), 64'd1);
      @(posedge clk);
      @(negedge clk);
      set_in(1, 12, 0, 1, 0, 13, 1, 0, 0, 0);
      #1 chk("rst_seq pre stall", 64'(stall), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_seq stall", 64'(stall), 64'd0);
      chk("rst_seq accept", 64'(issue_accept), 64'd1);
      chk("rst_seq rs1_sel", 64'(rs1_fwd_sel), 64'd0);
      chk("rst_seq wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_seq count", 64'(stall_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Randomized run against the queue-based model.
      for (int c = 0; c < 3000; c++) begin
         set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
         cnt_clr = $urandom_range(0, 99) == 0;
         rf_rs1_data = $urandom; rf_rs2_data = $urandom;
         sd[0] = $urandom; sd[1] = $urandom; sd[2] = $urandom;
         #1;
         lookup(issue_rs1_addr, issue_rs1_used, k1, r1);
         lookup(issue_rs2_addr, issue_rs2_used, k2, r2);
         hz1 = k1 >= 0 && !r1;
         hz2 = k2 >= 0 && !r2;
         e_st = issue_valid && !flush && (hz1 || hz2);
         e_acc = issue_valid && !e_st && !flush && !mem_busy;
         chk("rnd stall", 64'(stall), 64'(e_st));
         chk("rnd accept", 64'(issue_accept), 64'(e_acc));
         if (!hz1) begin
            chk("rnd rs1_sel", 64'(rs1_fwd_sel), 64'(k1 + 1));
            chk("rnd rs1_data", 64'(rs1_data), 64'(k1 < 0 ? rf_rs1_data : sd[k1]));
         end
         if (!hz2) begin
            chk("rnd rs2_sel", 64'(rs2_fwd_sel), 64'(k2 + 1));
            chk("rnd rs2_data", 64'(rs2_data), 64'(k2 < 0 ? rf_rs2_data : sd[k2]));
         end
         chk("rnd wb_valid", 64'(wb_valid), 64'(pipe[NS-1].v));
         if (pipe[NS-1].v) begin
            chk("rnd wb_rd", 64'(wb_rd_addr), 64'(pipe[NS-1].rd));
            chk("rnd wb_we", 64'(wb_rd_we), 64'(pipe[NS-1].we));
         end
         chk("rnd count", 64'(stall_count), 64'(mcnt));
         chk("rnd count_sat", 64'(s_count), 64'(mcnt_sat));
         @(posedge clk);
         if (!mem_busy) begin
            e.v = e_acc; e.rd = issue_rd_addr; e.we = issue_rd_we; e.ld = issue_is_load;
            void'(pipe.pop_back());
            pipe.push_front(e_acc ? e : mslot_t'('0));
         end
         if (cnt_clr) begin
            mcnt = 0;
            mcnt_sat = 0;
         end else if (e_st && !mem_busy) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt_sat < 3) mcnt_sat++;
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
